// File: rtl/rename_dispatch.sv
// Two-wide rename and dispatch stage: front RAT, physical free list and three
// reservation stations (ALU, load/store, branch), each issuing at most one entry per cycle.
module rename_dispatch #(
  parameter int ARCH_REGS      = 32,
  parameter int PHY_REGS       = 64,
  parameter int PHY_WIDTH      = 6,
  parameter int ROB_WIDTH      = 5,
  parameter int NUM_RS_ENTRIES = 8,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [1:0]                   in_valid,
  output logic                         in_ready,
  input  logic [1:0]                   opclass_0,
  input  logic [1:0]                   opclass_1,
  input  logic [$clog2(ARCH_REGS)-1:0] rs1_arch_0,
  input  logic [$clog2(ARCH_REGS)-1:0] rs1_arch_1,
  input  logic [$clog2(ARCH_REGS)-1:0] rs2_arch_0,
  input  logic [$clog2(ARCH_REGS)-1:0] rs2_arch_1,
  input  logic [$clog2(ARCH_REGS)-1:0] rd_arch_0,
  input  logic [$clog2(ARCH_REGS)-1:0] rd_arch_1,
  input  logic [ROB_WIDTH-1:0]         rob_id_0,
  input  logic [ROB_WIDTH-1:0]         rob_id_1,
  input  logic [DATA_WIDTH-1:0]        payload_0,
  input  logic [DATA_WIDTH-1:0]        payload_1,
  output logic [PHY_WIDTH-1:0]         rd_phy_new_0,
  output logic [PHY_WIDTH-1:0]         rd_phy_new_1,
  output logic [PHY_WIDTH-1:0]         rd_phy_old_0,
  output logic [PHY_WIDTH-1:0]         rd_phy_old_1,
  input  logic [PHY_REGS-1:0]          prf_busy,
  input  logic [1:0]                   free_valid,
  input  logic [PHY_WIDTH-1:0]         free_phy_0,
  input  logic [PHY_WIDTH-1:0]         free_phy_1,
  output logic                         issue_alu_valid,
  output logic [ROB_WIDTH-1:0]         issue_alu_rob_id,
  output logic [PHY_WIDTH-1:0]         issue_alu_rs1_phy,
  output logic [PHY_WIDTH-1:0]         issue_alu_rs2_phy,
  output logic [PHY_WIDTH-1:0]         issue_alu_rd_phy,
  output logic [DATA_WIDTH-1:0]        issue_alu_payload,
  output logic                         issue_ls_valid,
  output logic [ROB_WIDTH-1:0]         issue_ls_rob_id,
  output logic [PHY_WIDTH-1:0]         issue_ls_rs1_phy,
  output logic [PHY_WIDTH-1:0]         issue_ls_rs2_phy,
  output logic [PHY_WIDTH-1:0]         issue_ls_rd_phy,
  output logic [DATA_WIDTH-1:0]        issue_ls_payload,
  output logic                         issue_br_valid,
  output logic [ROB_WIDTH-1:0]         issue_br_rob_id,
  output logic [PHY_WIDTH-1:0]         issue_br_rs1_phy,
  output logic [PHY_WIDTH-1:0]         issue_br_rs2_phy,
  output logic [PHY_WIDTH-1:0]         issue_br_rd_phy,
  output logic [DATA_WIDTH-1:0]        issue_br_payload
);

  localparam int NUM_ST = 3;
  localparam int RS_IDX = $clog2(NUM_RS_ENTRIES);
  localparam int CNT_W  = $clog2(PHY_REGS + 1);
  localparam logic [1:0] ST_ALU = 2'd0;
  localparam logic [1:0] ST_LS  = 2'd1;
  localparam logic [1:0] ST_BR  = 2'd2;

  logic [PHY_WIDTH-1:0] rat [ARCH_REGS];
  logic [PHY_WIDTH-1:0] fl [PHY_REGS];
  logic [PHY_WIDTH-1:0] head, tail, head1, tail1;
  logic [CNT_W-1:0]     fl_count, cnt_mid;

  logic [NUM_RS_ENTRIES-1:0] st_valid [NUM_ST];
  logic [ROB_WIDTH-1:0]      st_rob  [NUM_ST][NUM_RS_ENTRIES];
  logic [PHY_WIDTH-1:0]      st_src1 [NUM_ST][NUM_RS_ENTRIES];
  logic [PHY_WIDTH-1:0]      st_src2 [NUM_ST][NUM_RS_ENTRIES];
  logic [PHY_WIDTH-1:0]      st_dst  [NUM_ST][NUM_RS_ENTRIES];
  logic [DATA_WIDTH-1:0]     st_pay  [NUM_ST][NUM_RS_ENTRIES];

  logic [RS_IDX:0]   st_free_cnt  [NUM_ST];
  logic [RS_IDX-1:0] st_free0     [NUM_ST];
  logic [RS_IDX-1:0] st_free1     [NUM_ST];
  logic              st_iss_found [NUM_ST];
  logic [RS_IDX-1:0] st_iss_idx   [NUM_ST];

  logic                  iss_valid [NUM_ST];
  logic [ROB_WIDTH-1:0]  iss_rob   [NUM_ST];
  logic [PHY_WIDTH-1:0]  iss_src1  [NUM_ST];
  logic [PHY_WIDTH-1:0]  iss_src2  [NUM_ST];
  logic [PHY_WIDTH-1:0]  iss_dst   [NUM_ST];
  logic [DATA_WIDTH-1:0] iss_pay   [NUM_ST];

  logic                 acc0, acc1, pop0, pop1, push0, push1;
  logic [PHY_WIDTH-1:0] s0_rs1, s0_rs2, s1_rs1, s1_rs2;
  logic [1:0]           cls0, cls1;
  logic [RS_IDX-1:0]    slot0_idx, slot1_idx;

  function automatic logic [1:0] station_of(input logic [1:0] opclass);
    if (opclass == 2'd1) return ST_LS;
    if (opclass == 2'd2) return ST_BR;
    return ST_ALU;
  endfunction

  function automatic logic tag_ready(input logic [PHY_WIDTH-1:0] tag,
                                     input logic [PHY_REGS-1:0]  busy);
    return (tag == '0) || !busy[tag];
  endfunction

  // Downward scan leaves the lowest free/ready index last; f1 is only meaningful with >= 2 free.
  always_comb begin
    for (int s = 0; s < NUM_ST; s++) begin
      logic [RS_IDX:0]   cnt;
      logic [RS_IDX-1:0] f0, f1, idx;
      logic              found;
      cnt   = '0;
      f0    = '0;
      f1    = '0;
      idx   = '0;
      found = 1'b0;
      for (int e = NUM_RS_ENTRIES - 1; e >= 0; e--) begin
        if (!st_valid[s][e]) begin
          cnt = cnt + (RS_IDX + 1)'(1);
          f1  = f0;
          f0  = RS_IDX'(e);
        end else if (tag_ready(st_src1[s][e], prf_busy) && tag_ready(st_src2[s][e], prf_busy)) begin
          found = 1'b1;
          idx   = RS_IDX'(e);
        end
      end
      st_free_cnt[s]  = cnt;
      st_free0[s]     = f0;
      st_free1[s]     = f1;
      st_iss_found[s] = found;
      st_iss_idx[s]   = idx;
    end
  end

  always_comb begin
    in_ready = (fl_count >= CNT_W'(2));
    for (int s = 0; s < NUM_ST; s++) begin
      if (st_free_cnt[s] < (RS_IDX + 1)'(2)) in_ready = 1'b0;
    end
  end

  assign acc0  = in_ready & in_valid[0];
  assign acc1  = in_ready & in_valid[1];
  assign pop0  = acc0 && (rd_arch_0 != '0);
  assign pop1  = acc1 && (rd_arch_1 != '0);
  assign head1 = head + PHY_WIDTH'(1);
  assign tail1 = tail + PHY_WIDTH'(1);

  assign rd_phy_new_0 = pop0 ? fl[head] : '0;
  assign rd_phy_new_1 = !pop1 ? '0 : (pop0 ? fl[head1] : fl[head]);
  assign rd_phy_old_0 = pop0 ? rat[rd_arch_0] : '0;
  assign rd_phy_old_1 = !pop1 ? '0 :
                        (pop0 && rd_arch_1 == rd_arch_0) ? rd_phy_new_0 : rat[rd_arch_1];

  // Slot 1 sees slot 0's fresh mapping when it reads the register slot 0 writes.
  assign s0_rs1 = rat[rs1_arch_0];
  assign s0_rs2 = rat[rs2_arch_0];
  assign s1_rs1 = (pop0 && rs1_arch_1 == rd_arch_0) ? rd_phy_new_0 : rat[rs1_arch_1];
  assign s1_rs2 = (pop0 && rs2_arch_1 == rd_arch_0) ? rd_phy_new_0 : rat[rs2_arch_1];

  assign cls0      = station_of(opclass_0);
  assign cls1      = station_of(opclass_1);
  assign slot0_idx = st_free0[cls0];
  assign slot1_idx = (acc0 && cls1 == cls0) ? st_free1[cls1] : st_free0[cls1];

  // Returned tags are only dropped when the list would overflow after this cycle's pops.
  always_comb begin
    cnt_mid = fl_count - CNT_W'(pop0) - CNT_W'(pop1);
    push0   = free_valid[0] && (cnt_mid < CNT_W'(PHY_REGS));
    push1   = free_valid[1] && ((cnt_mid + CNT_W'(push0)) < CNT_W'(PHY_REGS));
  end

  // Head and tail wrap naturally because PHY_REGS is 2**PHY_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PHY_WIDTH'(i);
      for (int i = 0; i < PHY_REGS; i++) fl[i] <= PHY_WIDTH'(i);
      head     <= PHY_WIDTH'(ARCH_REGS);
      tail     <= '0;
      fl_count <= CNT_W'(PHY_REGS - ARCH_REGS);
    end else begin
      if (pop0) rat[rd_arch_0] <= rd_phy_new_0;
      if (pop1) rat[rd_arch_1] <= rd_phy_new_1;
      if (push0) fl[tail] <= free_phy_0;
      if (push1) fl[push0 ? tail1 : tail] <= free_phy_1;
      head     <= head + PHY_WIDTH'(pop0) + PHY_WIDTH'(pop1);
      tail     <= tail + PHY_WIDTH'(push0) + PHY_WIDTH'(push1);
      fl_count <= cnt_mid + CNT_W'(push0) + CNT_W'(push1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < NUM_ST; s++) begin
        st_valid[s]  <= '0;
        iss_valid[s] <= 1'b0;
        iss_rob[s]   <= '0;
        iss_src1[s]  <= '0;
        iss_src2[s]  <= '0;
        iss_dst[s]   <= '0;
        iss_pay[s]   <= '0;
        for (int e = 0; e < NUM_RS_ENTRIES; e++) begin
          st_rob[s][e]  <= '0;
          st_src1[s][e] <= '0;
          st_src2[s][e] <= '0;
          st_dst[s][e]  <= '0;
          st_pay[s][e]  <= '0;
        end
      end
    end else begin
      for (int s = 0; s < NUM_ST; s++) begin
        iss_valid[s] <= st_iss_found[s];
        if (st_iss_found[s]) begin
          iss_rob[s]                 <= st_rob[s][st_iss_idx[s]];
          iss_src1[s]                <= st_src1[s][st_iss_idx[s]];
          iss_src2[s]                <= st_src2[s][st_iss_idx[s]];
          iss_dst[s]                 <= st_dst[s][st_iss_idx[s]];
          iss_pay[s]                 <= st_pay[s][st_iss_idx[s]];
          st_valid[s][st_iss_idx[s]] <= 1'b0;
        end
      end
      if (acc0) begin
        st_valid[cls0][slot0_idx] <= 1'b1;
        st_rob[cls0][slot0_idx]   <= rob_id_0;
        st_src1[cls0][slot0_idx]  <= s0_rs1;
        st_src2[cls0][slot0_idx]  <= s0_rs2;
        st_dst[cls0][slot0_idx]   <= rd_phy_new_0;
        st_pay[cls0][slot0_idx]   <= payload_0;
      end
      if (acc1) begin
        st_valid[cls1][slot1_idx] <= 1'b1;
        st_rob[cls1][slot1_idx]   <= rob_id_1;
        st_src1[cls1][slot1_idx]  <= s1_rs1;
        st_src2[cls1][slot1_idx]  <= s1_rs2;
        st_dst[cls1][slot1_idx]   <= rd_phy_new_1;
        st_pay[cls1][slot1_idx]   <= payload_1;
      end
    end
  end

  assign issue_alu_valid   = iss_valid[ST_ALU];
  assign issue_alu_rob_id  = iss_rob[ST_ALU];
  assign issue_alu_rs1_phy = iss_src1[ST_ALU];
  assign issue_alu_rs2_phy = iss_src2[ST_ALU];
  assign issue_alu_rd_phy  = iss_dst[ST_ALU];
  assign issue_alu_payload = iss_pay[ST_ALU];
  assign issue_ls_valid    = iss_valid[ST_LS];
  assign issue_ls_rob_id   = iss_rob[ST_LS];
  assign issue_ls_rs1_phy  = iss_src1[ST_LS];
  assign issue_ls_rs2_phy  = iss_src2[ST_LS];
  assign issue_ls_rd_phy   = iss_dst[ST_LS];
  assign issue_ls_payload  = iss_pay[ST_LS];
  assign issue_br_valid    = iss_valid[ST_BR];
  assign issue_br_rob_id   = iss_rob[ST_BR];
  assign issue_br_rs1_phy  = iss_src1[ST_BR];
  assign issue_br_rs2_phy  = iss_src2[ST_BR];
  assign issue_br_rd_phy   = iss_dst[ST_BR];
  assign issue_br_payload  = iss_pay[ST_BR];

endmodule

// File: tb/tb_rename_dispatch.sv
// Directed self-checking bench for rename_dispatch: rename tags, bypass, routing,
// busy-source wakeup, reset flush, free-list exhaustion and station-full backpressure.
module tb_rename_dispatch;

  localparam logic [1:0] ALU = 2'd0;
  localparam logic [1:0] LS  = 2'd1;
  localparam logic [1:0] BR  = 2'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  in_valid;
  logic        in_ready;
  logic [1:0]  opclass_0, opclass_1;
  logic [4:0]  rs1_arch_0, rs1_arch_1, rs2_arch_0, rs2_arch_1, rd_arch_0, rd_arch_1;
  logic [4:0]  rob_id_0, rob_id_1;
  logic [31:0] payload_0, payload_1;
  logic [5:0]  rd_phy_new_0, rd_phy_new_1, rd_phy_old_0, rd_phy_old_1;
  logic [63:0] prf_busy;
  logic [1:0]  free_valid;
  logic [5:0]  free_phy_0, free_phy_1;
  logic        issue_alu_valid, issue_ls_valid, issue_br_valid;
  logic [4:0]  issue_alu_rob_id, issue_ls_rob_id, issue_br_rob_id;
  logic [5:0]  issue_alu_rs1_phy, issue_alu_rs2_phy, issue_alu_rd_phy;
  logic [5:0]  issue_ls_rs1_phy, issue_ls_rs2_phy, issue_ls_rd_phy;
  logic [5:0]  issue_br_rs1_phy, issue_br_rs2_phy, issue_br_rd_phy;
  logic [31:0] issue_alu_payload, issue_ls_payload, issue_br_payload;

  int          compared = 0;
  int          mismatched = 0;
  logic [4:0]  rob_next = 5'd0;
  logic [4:0]  exp_rob0, exp_rob1;
  logic [31:0] exp_pay0;

  rename_dispatch dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .opclass_0(opclass_0), .opclass_1(opclass_1),
    .rs1_arch_0(rs1_arch_0), .rs1_arch_1(rs1_arch_1),
    .rs2_arch_0(rs2_arch_0), .rs2_arch_1(rs2_arch_1),
    .rd_arch_0(rd_arch_0), .rd_arch_1(rd_arch_1),
    .rob_id_0(rob_id_0), .rob_id_1(rob_id_1),
    .payload_0(payload_0), .payload_1(payload_1),
    .rd_phy_new_0(rd_phy_new_0), .rd_phy_new_1(rd_phy_new_1),
    .rd_phy_old_0(rd_phy_old_0), .rd_phy_old_1(rd_phy_old_1),
    .prf_busy(prf_busy), .free_valid(free_valid),
    .free_phy_0(free_phy_0), .free_phy_1(free_phy_1),
    .issue_alu_valid(issue_alu_valid), .issue_alu_rob_id(issue_alu_rob_id),
    .issue_alu_rs1_phy(issue_alu_rs1_phy), .issue_alu_rs2_phy(issue_alu_rs2_phy),
    .issue_alu_rd_phy(issue_alu_rd_phy), .issue_alu_payload(issue_alu_payload),
    .issue_ls_valid(issue_ls_valid), .issue_ls_rob_id(issue_ls_rob_id),
    .issue_ls_rs1_phy(issue_ls_rs1_phy), .issue_ls_rs2_phy(issue_ls_rs2_phy),
    .issue_ls_rd_phy(issue_ls_rd_phy), .issue_ls_payload(issue_ls_payload),
    .issue_br_valid(issue_br_valid), .issue_br_rob_id(issue_br_rob_id),
    .issue_br_rs1_phy(issue_br_rs1_phy), .issue_br_rs2_phy(issue_br_rs2_phy),
    .issue_br_rd_phy(issue_br_rd_phy), .issue_br_payload(issue_br_payload)
  );

  always #5 clk = ~clk;

  // Drives a rename group; rob ids and payloads come from a bench-side counter.
  task automatic applyStimulus(input logic [1:0] v,
                               input logic [1:0] op0, input logic [4:0] rd0, input logic [4:0] a0, input logic [4:0] b0,
                               input logic [1:0] op1, input logic [4:0] rd1, input logic [4:0] a1, input logic [4:0] b1);
    in_valid   = v;
    opclass_0  = op0;
    rd_arch_0  = rd0;
    rs1_arch_0 = a0;
    rs2_arch_0 = b0;
    opclass_1  = op1;
    rd_arch_1  = rd1;
    rs1_arch_1 = a1;
    rs2_arch_1 = b1;
    rob_id_0   = rob_next;
    rob_id_1   = rob_next + 5'd1;
    payload_0  = 32'hC0DE_0000 + 32'(rob_next);
    payload_1  = 32'hBEEF_0000 + 32'(rob_next);
    rob_next   = rob_next + 5'd2;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected)
      else begin
        mismatched++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    prf_busy = '0;
    free_valid = 2'b00;
    free_phy_0 = '0;
    free_phy_1 = '0;
    applyStimulus(2'b00, ALU, 0, 0, 0, ALU, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_alu_valid", 32'(issue_alu_valid), 32'd0);
    checkOutput("reset_ls_valid", 32'(issue_ls_valid), 32'd0);
    checkOutput("reset_br_valid", 32'(issue_br_valid), 32'd0);
    checkOutput("reset_new0", 32'(rd_phy_new_0), 32'd0);
    checkOutput("reset_alu_rd", 32'(issue_alu_rd_phy), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] single add");
    applyStimulus(2'b01, ALU, 3, 1, 2, ALU, 0, 0, 0);
    exp_rob0 = rob_id_0;
    exp_pay0 = payload_0;
    #1;
    checkOutput("add_new0", 32'(rd_phy_new_0), 32'd32);
    checkOutput("add_old0", 32'(rd_phy_old_0), 32'd3);
    checkOutput("add_new1", 32'(rd_phy_new_1), 32'd0);
    tick();
    prf_busy[32] = 1'b1;
    in_valid = 2'b00;
    #1;
    checkOutput("add_not_same_edge", 32'(issue_alu_valid), 32'd0);
    tick();
    checkOutput("add_issue_valid", 32'(issue_alu_valid), 32'd1);
    checkOutput("add_issue_rs1", 32'(issue_alu_rs1_phy), 32'd1);
    checkOutput("add_issue_rs2", 32'(issue_alu_rs2_phy), 32'd2);
    checkOutput("add_issue_rd", 32'(issue_alu_rd_phy), 32'd32);
    checkOutput("add_issue_rob", 32'(issue_alu_rob_id), 32'(exp_rob0));
    checkOutput("add_issue_payload", issue_alu_payload, exp_pay0);
    tick();
    checkOutput("add_one_cycle", 32'(issue_alu_valid), 32'd0);

    $display("[TB] stuck consumer then reset");
    applyStimulus(2'b01, ALU, 0, 3, 0, ALU, 0, 0, 0);
    #1;
    checkOutput("nodest_new0", 32'(rd_phy_new_0), 32'd0);
    checkOutput("nodest_old0", 32'(rd_phy_old_0), 32'd0);
    tick();
    in_valid = 2'b00;
    tick();
    checkOutput("busy_stuck", 32'(issue_alu_valid), 32'd0);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    prf_busy = '0;
    tick();
    tick();
    checkOutput("reset_flush", 32'(issue_alu_valid), 32'd0);

    $display("[TB] intra-group dependency");
    applyStimulus(2'b11, ALU, 4, 1, 2, ALU, 4, 4, 5);
    exp_rob0 = rob_id_0;
    exp_rob1 = rob_id_1;
    #1;
    checkOutput("dep_new0", 32'(rd_phy_new_0), 32'd32);
    checkOutput("dep_old0", 32'(rd_phy_old_0), 32'd4);
    checkOutput("dep_new1", 32'(rd_phy_new_1), 32'd33);
    checkOutput("dep_old1", 32'(rd_phy_old_1), 32'd32);
    tick();
    prf_busy[32] = 1'b1;
    prf_busy[33] = 1'b1;
    in_valid = 2'b00;
    tick();
    checkOutput("dep_first_valid", 32'(issue_alu_valid), 32'd1);
    checkOutput("dep_first_rd", 32'(issue_alu_rd_phy), 32'd32);
    checkOutput("dep_first_rob", 32'(issue_alu_rob_id), 32'(exp_rob0));
    tick();
    checkOutput("dep_waits", 32'(issue_alu_valid), 32'd0);
    tick();
    checkOutput("dep_still_waits", 32'(issue_alu_valid), 32'd0);
    prf_busy[32] = 1'b0;
    tick();
    checkOutput("wake_valid", 32'(issue_alu_valid), 32'd1);
    checkOutput("wake_rs1", 32'(issue_alu_rs1_phy), 32'd32);
    checkOutput("wake_rs2", 32'(issue_alu_rs2_phy), 32'd5);
    checkOutput("wake_rd", 32'(issue_alu_rd_phy), 32'd33);
    checkOutput("wake_rob", 32'(issue_alu_rob_id), 32'(exp_rob1));

    $display("[TB] class routing");
    applyStimulus(2'b11, LS, 4, 6, 7, BR, 0, 8, 0);
    exp_rob1 = rob_id_1;
    #1;
    checkOutput("route_old0_rat4", 32'(rd_phy_old_0), 32'd33);
    checkOutput("route_new0", 32'(rd_phy_new_0), 32'd34);
    checkOutput("route_new1", 32'(rd_phy_new_1), 32'd0);
    tick();
    prf_busy[34] = 1'b1;
    in_valid = 2'b00;
    tick();
    checkOutput("route_ls_valid", 32'(issue_ls_valid), 32'd1);
    checkOutput("route_br_valid", 32'(issue_br_valid), 32'd1);
    checkOutput("route_ls_rd", 32'(issue_ls_rd_phy), 32'd34);
    checkOutput("route_ls_rs2", 32'(issue_ls_rs2_phy), 32'd7);
    checkOutput("route_br_rs1", 32'(issue_br_rs1_phy), 32'd8);
    checkOutput("route_br_rob", 32'(issue_br_rob_id), 32'(exp_rob1));

    $display("[TB] free list exhaustion");
    for (int k = 0; k < 14; k++) begin
      checkOutput("fl_ready_before", 32'(in_ready), 32'd1);
      applyStimulus(2'b11, ALU, 10, 0, 0, LS, 11, 0, 0);
      #1;
      checkOutput("fl_new0", 32'(rd_phy_new_0), 32'(35 + 2 * k));
      checkOutput("fl_new1", 32'(rd_phy_new_1), 32'(36 + 2 * k));
      tick();
    end
    applyStimulus(2'b11, ALU, 12, 0, 0, LS, 13, 0, 0);
    free_valid = 2'b01;
    free_phy_0 = 6'd32;
    #1;
    checkOutput("fl_low_ready", 32'(in_ready), 32'd0);
    checkOutput("fl_low_no_accept", 32'(rd_phy_new_0), 32'd0);
    tick();
    free_valid = 2'b00;
    in_valid = 2'b00;
    #1;
    checkOutput("fl_push_ready", 32'(in_ready), 32'd1);

    $display("[TB] station fill");
    for (int j = 0; j < 3; j++) begin
      applyStimulus(2'b11, ALU, 0, 4, 0, ALU, 0, 4, 0);
      if (j == 0) exp_rob0 = rob_id_0;
      tick();
    end
    in_valid = 2'b00;
    #1;
    checkOutput("st_six_ready", 32'(in_ready), 32'd1);
    applyStimulus(2'b01, ALU, 0, 4, 0, ALU, 0, 0, 0);
    tick();
    in_valid = 2'b00;
    #1;
    checkOutput("st_seven_block", 32'(in_ready), 32'd0);
    checkOutput("st_none_ready", 32'(issue_alu_valid), 32'd0);
    prf_busy[34] = 1'b0;
    tick();
    checkOutput("st_drain_valid", 32'(issue_alu_valid), 32'd1);
    checkOutput("st_drain_lowest", 32'(issue_alu_rob_id), 32'(exp_rob0));
    checkOutput("st_drain_rs1", 32'(issue_alu_rs1_phy), 32'd34);
    checkOutput("st_drain_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/rename_dispatch.md
# rename_dispatch

Two-wide rename-and-dispatch block for the out-of-order core. It combines the front register alias table, the physical-register free list, and three small reservation stations (ALU, load/store, branch). It sits between decode/ROB allocation and the execution units. Each cycle it accepts up to two decoded instructions, renames their registers, writes them into the matching reservation station, and issues at most one ready instruction per station.

## Interface
- ARCH_REGS, 32: architectural registers.
- PHY_REGS, 64: physical registers.
- PHY_WIDTH, 6: physical tag width.
- ROB_WIDTH, 5: ROB id width.
- NUM_RS_ENTRIES, 8: entries per reservation station.
- DATA_WIDTH, 32: opaque payload width (immediate/opcode bits).

Ports:
- clk  in  1  clock; single clock domain.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  2  per-slot valid; slot 0 is older.
- in_ready  out  1  group accepted when high; all-or-nothing.
- opclass_0/1  in  2  0=ALU, 1=LS, 2=BR; 3 is treated as ALU.
- rs1_arch_0/1, rs2_arch_0/1, rd_arch_0/1  in  5  architectural registers; rd=0 means no destination.
- rob_id_0/1  in  ROB_WIDTH  ROB id allocated upstream.
- payload_0/1  in  DATA_WIDTH  carried unchanged to issue.
- rd_phy_new_0/1  out  PHY_WIDTH  newly allocated tag, 0 if none.
- rd_phy_old_0/1  out  PHY_WIDTH  previous mapping of rd, for the ROB; 0 if none.
- prf_busy  in  PHY_REGS  bit set means the physical register's value is not yet written.
- free_valid  in  2  commit returns tags to the free list.
- free_phy_0/1  in  PHY_WIDTH  returned tags.
- For X in {alu, ls, br}, issue outputs:
  - issue_X_valid  out  1
  - issue_X_rob_id  out  ROB_WIDTH
  - issue_X_rs1_phy, issue_X_rs2_phy, issue_X_rd_phy  out  PHY_WIDTH
  - issue_X_payload  out  DATA_WIDTH

## Operation
- **RAT:** 32 entries of PHY_WIDTH. Reset is identity (arch i → phys i). Entry 0 is never written.
- **Free list:** circular FIFO of PHY_REGS entries with head, tail and count.
  - Reset contents: tags ARCH_REGS..PHY_REGS-1 in ascending order; head at tag 32; count = PHY_REGS-ARCH_REGS.
  - Pushes while full are dropped.
- **Readiness:** in_ready = (free count ≥ 2) AND (each of the three stations has ≥ 2 free entries). It depends only on state, never on in_valid. Accept = in_ready and the slot's in_valid bit is set.
- **Allocation:** every accepted slot with rd≠0 pops one tag. Slot 0 pops first; if slot 0 needs none, slot 1 takes the head.
- **Source lookup:** uses the RAT before this cycle's update, with an intra-group bypass. If slot 1's rs1 or rs2 equals slot 0's rd (≠0), it takes rd_phy_new_0.
- **Destination write:** rd_phy_old_1 = rd_phy_new_0 when both slots write the same rd. The RAT then ends holding rd_phy_new_1.
- **Output timing:** rd_phy_new and rd_phy_old are combinational in the accept cycle.
- **PRF busy (external):** the PRF owner must set prf_busy for each rd_phy_new at the accept edge.
- **Dispatch:** each accepted slot is written to the lowest-index free entry of the station chosen by opclass. When both slots target the same station, slot 0 takes the lower index. An entry holds rob_id, the three tags and the payload.
- **Issue:** each cycle every station selects its lowest-index valid entry whose rs1 and rs2 busy bits are both clear. Tag 0 is always ready.
  - The selected entry is copied to the issue registers and invalidated at the edge.
  - Issue is unconditional; there is no downstream backpressure.
- **Frees:** free_valid pushes slot 0 then slot 1 at the edge. The free count used for in_ready is the pre-edge count.

## Timing
- **Reset** (asynchronous): all stations empty, every issue_*_valid=0, issue data=0, RAT identity, free list reset, rename outputs 0.
- **Rename:** 0 cycles. Tags are valid combinationally during the accept cycle; RAT and free list update at that edge.
- **Dispatch-to-issue:** minimum 1 cycle. An instruction accepted at edge N with ready sources shows issue_X_valid=1 after edge N+1, held for exactly one cycle unless another entry issues.
- **Same-edge insertion:** an entry becoming ready in the same edge it is inserted is not issued in that edge.
- **Simultaneous events:** allocate and free in the same cycle are both applied. Free count = count − pops + pushes.
- **Count limits:** the count never exceeds PHY_REGS. Head and tail wrap modulo PHY_REGS.
- **Reset mid-operation:** discards all station contents and all in-flight renames.

## Test plan
- **Reset:** after reset, in_ready=1, free count 32, RAT[5]=5, all issue_*_valid=0.
- **Single add:** slot0 ALU with rd=3, rs1=1, rs2=2, prf_busy=0 → rd_phy_new_0=32, rd_phy_old_0=3; next cycle issue_alu_valid=1 with rs1_phy=1, rs2_phy=2, rd_phy=32.
- **Intra-group dependency:** slot0 rd=4, slot1 rd=4 with rs1=4 → slot1 rs1_phy=32, rd_phy_new_1=33, rd_phy_old_1=32; RAT[4]=33 afterwards.
- **Class routing:** slot0 LS, slot1 BR, both ready → issue_ls_valid and issue_br_valid both 1 in the same cycle.
- **Busy source:** keep prf_busy[32]=1 → the consumer stays in its station; clearing bit 32 produces issue on the following edge.
- **Free list exhaustion:** allocate 31 tags → in_ready=0; one free_valid push → in_ready=1. Also check a station filled to 7 entries drops in_ready.
